// File: rtl/smarthome_defs.sv
// Shared definitions for the smarthome sensor front ends: frame geometry,
// sign-magnitude constants and the ADC reader FSM state encoding.
package smarthome_defs;

  localparam int ADC_FRAME_BITS = 16;
  localparam int SM_SIGN_BIT    = 15;

  typedef logic [ADC_FRAME_BITS-1:0] adc_word_t;

  localparam adc_word_t SM_NEG_FULL = 16'hFFFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/adc_serial_reader_twos_to_signmag.sv
// Combinational two's-complement to sign-magnitude converter; the most negative
// code has no sign-magnitude equivalent and saturates to -32767.
module twos_to_signmag
  import smarthome_defs::*;
(
  input  logic [ADC_FRAME_BITS-1:0] raw,
  output logic [ADC_FRAME_BITS-1:0] sm
);

  function automatic adc_word_t sat_signmag(input logic signed [ADC_FRAME_BITS-1:0] v);
    logic signed [ADC_FRAME_BITS-1:0] mag;
    mag = -v;
    if (v == $signed(16'h8000)) begin
      return SM_NEG_FULL;
    end else if (v < 0) begin
      return {1'b1, mag[SM_SIGN_BIT-1:0]};
    end else begin
      return {1'b0, v[SM_SIGN_BIT-1:0]};
    end
  endfunction

  assign sm = sat_signmag(raw);

endmodule

// File: rtl/adc_serial_reader.sv
// SPI mode-0 read-only front end for the temperature ADC: periodic 16-bit frame
// capture, conversion to sign-magnitude, one-cycle valid strobe.
module adc_serial_reader
  import smarthome_defs::*;
#(
  parameter int SCLK_DIV      = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_sdo,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] adc_data,
  output logic        adc_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(SCLK_DIV + 1);

  logic [PW-1:0] period_cnt;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [2:0]    state;
  adc_word_t     shift_reg;
  adc_word_t     sm_word;
  logic          tick;
  logic          half_done;

  assign tick      = enable && (period_cnt == '0);
  assign half_done = (div_cnt == DW'(SCLK_DIV - 1));
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (!enable) begin
      period_cnt <= '0;
    end else if (period_cnt == PW'(SAMPLE_PERIOD - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b0;
      adc_data  <= '0;
      adc_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      adc_valid <= 1'b0;
      // A start that arrives while a frame is in flight is dropped, not queued.
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state    <= ST_SETUP;
            adc_cs_n <= 1'b0;
            div_cnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (half_done) begin
            state   <= ST_SHIFT;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (half_done) begin
            div_cnt  <= '0;
            adc_sclk <= ~adc_sclk;
            if (adc_sclk) begin
              if (bit_cnt == 4'd15) state <= ST_HOLD;
              else bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (half_done) begin
            state     <= ST_DONE;
            div_cnt   <= '0;
            adc_cs_n  <= 1'b1;
            adc_data  <= sm_word;
            adc_valid <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture on the clk edge that raises sclk; MSB shifts in first.
  always_ff @(posedge clk) begin
    if (state == ST_SHIFT && half_done && !adc_sclk) begin
      shift_reg <= {shift_reg[ADC_FRAME_BITS-2:0], adc_sdo};
    end
  end

  twos_to_signmag u_conv (
    .raw (shift_reg),
    .sm  (sm_word)
  );

endmodule
